// File: rtl/enemy_hit_detector_pkg.sv
// ----------------------------------------------------------------------------
// enemy_hit_detector_pkg
// Shared geometry and FSM encodings for the enemy formation row. The renderer,
// the collision logic and the hit detector all take the row geometry from here,
// so they always agree on where each enemy box is.
// Contents:
//   COORD_W, NUM_ENEMIES, ENEMY_W, ENEMY_H, ENEMY_PITCH  geometry constants
//   ST_IDLE / ST_SCAN / ST_REPORT                        FSM state encodings
//   coord_ext_t                                          coordinate with one guard bit
//   snapshot_t                                           bullet/formation sample
//   enemy_origin_x()                                     left edge of enemy idx
// ----------------------------------------------------------------------------
package enemy_hit_detector_pkg;

    localparam int COORD_W     = 10;
    localparam int NUM_ENEMIES = 8;
    localparam int IDX_W       = 3;
    localparam int ENEMY_W     = 32;
    localparam int ENEMY_H     = 24;
    localparam int ENEMY_PITCH = 48;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SCAN   = 2'd1;
    localparam logic [1:0] ST_REPORT = 2'd2;

    // One extra bit so box origins to the right of the screen stay
    // out of reach of any on-screen coordinate instead of wrapping.
    typedef logic [COORD_W:0] coord_ext_t;

    typedef struct packed {
        logic [COORD_W-1:0] bx;
        logic [COORD_W-1:0] by;
        logic [COORD_W-1:0] fx;
        logic [COORD_W-1:0] fy;
    } snapshot_t;

    function automatic coord_ext_t enemy_origin_x(input logic [COORD_W-1:0] fx,
                                                  input logic [IDX_W-1:0]   idx);
        return {1'b0, fx} + (coord_ext_t'(idx) * coord_ext_t'(ENEMY_PITCH));
    endfunction

endpackage

// File: rtl/enemy_hit_detector_if.sv
// ----------------------------------------------------------------------------
// enemy_hit_detector_if
// Bundles the frame/bullet/formation inputs and the kill/status outputs of the
// hit detector. The master side (game logic) drives the inputs and reads the
// results; the slave side is the hit detector itself.
// Signals:
//   frame_tick, bullet_valid, bullet_x, bullet_y,
//   formation_x, formation_y, wave_reset          master -> slave
//   enemy_killed, bullet_hit, alive, all_dead, busy slave -> master
// ----------------------------------------------------------------------------
interface enemy_hit_detector_if;
    import enemy_hit_detector_pkg::*;

    logic                   frame_tick;
    logic                   bullet_valid;
    logic [COORD_W-1:0]     bullet_x;
    logic [COORD_W-1:0]     bullet_y;
    logic [COORD_W-1:0]     formation_x;
    logic [COORD_W-1:0]     formation_y;
    logic                   wave_reset;
    logic [NUM_ENEMIES-1:0] enemy_killed;
    logic                   bullet_hit;
    logic [NUM_ENEMIES-1:0] alive;
    logic                   all_dead;
    logic                   busy;

    modport master (
        output frame_tick, bullet_valid, bullet_x, bullet_y,
               formation_x, formation_y, wave_reset,
        input  enemy_killed, bullet_hit, alive, all_dead, busy
    );

    modport slave (
        input  frame_tick, bullet_valid, bullet_x, bullet_y,
               formation_x, formation_y, wave_reset,
        output enemy_killed, bullet_hit, alive, all_dead, busy
    );

endinterface

// File: rtl/enemy_hit_detector_box_hit_test.sv
// ----------------------------------------------------------------------------
// box_hit_test
// Combinational point-in-box test on guard-bit-extended coordinates. Left and
// top edges are inclusive, right and bottom edges exclusive.
// Ports:
//   pt_x_i, pt_y_i    point under test
//   box_x_i, box_y_i  box origin (top-left)
//   box_w_i, box_h_i  box size
//   hit_o             point lies inside the box
// ----------------------------------------------------------------------------
module box_hit_test
    import enemy_hit_detector_pkg::*;
(
    input  coord_ext_t pt_x_i,
    input  coord_ext_t pt_y_i,
    input  coord_ext_t box_x_i,
    input  coord_ext_t box_y_i,
    input  coord_ext_t box_w_i,
    input  coord_ext_t box_h_i,
    output logic       hit_o
);

    coord_ext_t box_x_end;
    coord_ext_t box_y_end;

    assign box_x_end = box_x_i + box_w_i;
    assign box_y_end = box_y_i + box_h_i;

    assign hit_o = (pt_x_i >= box_x_i) && (pt_x_i < box_x_end) &&
                   (pt_y_i >= box_y_i) && (pt_y_i < box_y_end);

endmodule

// File: rtl/enemy_hit_detector.sv
// ----------------------------------------------------------------------------
// enemy_hit_detector
// Keeps the alive bitmap of the 8-enemy row and, once per frame, sweeps the
// player bullet across the row one enemy per cycle. The first enemy hit is
// reported as a one-cycle one-hot kill pulse with a matching bullet_hit pulse,
// and is removed from the alive bitmap.
// Ports:
//   clk    system clock
//   rst_n  synchronous active-low reset
//   bus    enemy_hit_detector_if.slave (frame/bullet/formation in,
//          enemy_killed/bullet_hit/alive/all_dead/busy out)
//
// state  | meaning
// IDLE   | waiting for frame_tick with a bullet in flight
// SCAN   | testing enemy idx against the bullet snapshot, 8 cycles
// REPORT | kill pulse visible; killed bit removed from alive
// ----------------------------------------------------------------------------
module enemy_hit_detector
    import enemy_hit_detector_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    enemy_hit_detector_if.slave  bus
);

    logic [1:0]             state_q,        state_d;
    logic [IDX_W-1:0]       idx_q,          idx_d;
    snapshot_t              snap_q,         snap_d;
    logic                   hit_found_q,    hit_found_d;
    logic [IDX_W-1:0]       hit_idx_q,      hit_idx_d;
    logic [NUM_ENEMIES-1:0] alive_q,        alive_d;
    logic [NUM_ENEMIES-1:0] enemy_killed_q, enemy_killed_d;
    logic                   bullet_hit_q,   bullet_hit_d;
    logic                   busy_q,         busy_d;

    logic                   box_hit;
    logic                   cur_hit;

    box_hit_test u_box_hit_test (
        .pt_x_i  ({1'b0, snap_q.bx}),
        .pt_y_i  ({1'b0, snap_q.by}),
        .box_x_i (enemy_origin_x(snap_q.fx, idx_q)),
        .box_y_i ({1'b0, snap_q.fy}),
        .box_w_i (coord_ext_t'(ENEMY_W)),
        .box_h_i (coord_ext_t'(ENEMY_H)),
        .hit_o   (box_hit)
    );

    assign cur_hit = alive_q[idx_q] && box_hit;

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        snap_d         = snap_q;
        hit_found_d    = hit_found_q;
        hit_idx_d      = hit_idx_q;
        alive_d        = alive_q;
        busy_d         = busy_q;
        enemy_killed_d = '0;
        bullet_hit_d   = 1'b0;

        if (bus.wave_reset) begin
            alive_d = {NUM_ENEMIES{1'b1}};
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.frame_tick && bus.bullet_valid) begin
                        snap_d      = '{bx: bus.bullet_x,    by: bus.bullet_y,
                                        fx: bus.formation_x, fy: bus.formation_y};
                        hit_found_d = 1'b0;
                        hit_idx_d   = '0;
                        idx_d       = '0;
                        state_d     = ST_SCAN;
                        busy_d      = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (!hit_found_q && cur_hit) begin
                        hit_found_d = 1'b1;
                        hit_idx_d   = idx_q;
                    end
                    idx_d = idx_q + 1'b1;
                    // The last enemy's result is folded in here so the
                    // registered pulse lines up with the REPORT cycle.
                    if (idx_q == IDX_W'(NUM_ENEMIES - 1)) begin
                        state_d        = ST_REPORT;
                        enemy_killed_d = hit_found_d ? (NUM_ENEMIES'(1) << hit_idx_d) : '0;
                        bullet_hit_d   = hit_found_d;
                    end
                end
                ST_REPORT: begin
                    alive_d = alive_q & ~enemy_killed_q;
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            snap_q         <= '0;
            hit_found_q    <= 1'b0;
            hit_idx_q      <= '0;
            alive_q        <= {NUM_ENEMIES{1'b1}};
            enemy_killed_q <= '0;
            bullet_hit_q   <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            snap_q         <= snap_d;
            hit_found_q    <= hit_found_d;
            hit_idx_q      <= hit_idx_d;
            alive_q        <= alive_d;
            enemy_killed_q <= enemy_killed_d;
            bullet_hit_q   <= bullet_hit_d;
            busy_q         <= busy_d;
        end
    end

    assign bus.enemy_killed = enemy_killed_q;
    assign bus.bullet_hit   = bullet_hit_q;
    assign bus.alive        = alive_q;
    assign bus.all_dead     = (alive_q == '0);
    assign bus.busy         = busy_q;

endmodule
